data_memory: RTL and testbench
==============================

# data_memory

Single-port synchronous data memory: 256 × 8-bit by default, one read/write port, registered read data. Serves as the processor's data store, addressed directly by the datapath with a single write-enable strobe. All storage and the output register clear on an asynchronous active-high reset.

## Interface
- DATA_WIDTH, 8, word width in bits
- ADDR_WIDTH, 8, address width in bits
- DEPTH, 2**ADDR_WIDTH, number of words; the whole address space is populated
- clk  input  1  clock; all state changes on the rising edge except reset
- reset  input  1  asynchronous, active-high; clears all storage and output_data
- mem_write  input  1  write enable, sampled at the rising clk edge
- address  input  ADDR_WIDTH  word address for both read and write
- input_data  input  DATA_WIDTH  write data, sampled at the rising clk edge when mem_write=1
- output_data  output  DATA_WIDTH  registered read data

## Operation
- Storage: DEPTH words of DATA_WIDTH bits, with no wait states, handshake or error outputs.
- Write: at a rising edge with mem_write=1, mem[address] <= input_data.
- Read: at every rising edge, output_data <= mem[address], whatever the value of mem_write.
- Read-during-write (same edge, same address): behaviour is set by the configuration macro (see Configuration).
- mem_write=0: memory contents are unchanged.
- Reset:
  - While reset=1, every word reads as 0 and output_data=0.
  - Writes are ignored while reset=1.
  - Reset takes effect immediately, without a clock edge, and may be asserted mid-operation; any write on an edge where reset=1 is lost.
- Reset values: output_data=0; all mem words = 0.
- Address: always in range because DEPTH = 2**ADDR_WIDTH; no wrap logic is needed. Address 0xFF is a normal location.
- X/Z on inputs is outside the contract.

## Timing
- Write latency: data is in the array after the edge at which it is sampled.
- Read latency: 1 cycle. output_data reflects the address presented before rising edge N, valid after edge N, and holds until the next edge.
- Back-to-back writes and reads at one operation per cycle are supported; there is no turnaround cycle.
- Reset deassertion: the first edge with reset=0 performs normal operation.
- Inputs must meet setup and hold to the clk rising edge. Reset deassertion must be synchronous to clk, which is the system's responsibility.

## Configuration
- Macro: DATA_MEMORY_WRITE_THROUGH_EN.
- Defined: on a write edge, output_data <= input_data (the newly written value; write-first).
- Undefined: on a write edge, output_data <= the old mem[address] (read-first).
- All other behaviour is identical in both builds.

## Test plan
- Reset: assert reset=1 asynchronously between edges -> output_data=0 immediately. Deassert, then read addresses 0x00, 0x0A, 0xFF -> each returns 0x00.
- Write then read back:
  - Writes (mem_write=1, each held 2 cycles): 0xAA to 0x00, 0x55 to 0xFF, 0xF0 to 0x0A.
  - Reads (mem_write=0): 0x00 -> 0xAA, 0xFF -> 0x55, 0x0A -> 0xF0.
  - Each read value appears one edge after the address is applied.
- Write disabled: with mem_write=0, apply address 0x0A and input_data=0x12 for 3 cycles -> a subsequent read of 0x0A still returns 0xF0.
- Read-during-write: 0x0A holds 0xF0; write 0x3C to 0x0A.
  - Write edge: output_data=0x3C with the macro defined, 0xF0 without it.
  - Next read cycle: output_data=0x3C in both builds.
- Reset mid-operation: after the writes above, pulse reset during a write cycle -> output_data=0 at once, the write is lost, and reads of 0x00, 0xFF, 0x0A all return 0x00.
- Back-to-back: write 0x01..0x04 to addresses 0x10..0x13 on consecutive edges, then read them on consecutive edges -> output_data shows 0x01, 0x02, 0x03, 0x04 on successive cycles.

Source files
------------

// File: rtl/data_memory.sv
// Single-port data memory with registered read and asynchronous clear of every word.
// Optional build macro DATA_MEMORY_WRITE_THROUGH_EN selects write-first read-during-write.
module data_memory #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] input_data,
  output logic [DATA_WIDTH-1:0] output_data
);

  // Storage lives in flops, not block RAM, because reset must clear every word at once.
  logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
  logic [DATA_WIDTH-1:0] output_data_reg;
  logic [DATA_WIDTH-1:0] output_data_next;
  logic [DEPTH-1:0]      word_we;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word_we
      assign word_we[gi] = mem_write && (address == ADDR_WIDTH'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (word_we[i]) begin
          mem_reg[i] <= input_data;
        end
      end
    end
  end

  always_comb begin
    output_data_next = mem_reg[address];
`ifdef DATA_MEMORY_WRITE_THROUGH_EN
    if (mem_write) begin
      output_data_next = input_data;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      output_data_reg <= '0;
    end else begin
      output_data_reg <= output_data_next;
    end
  end

  assign output_data = output_data_reg;

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: array-level reference model checked every cycle,
// plus hand-computed literal expectations for each test-plan step.
module tb_data_memory;

  localparam int DW = 8;
  localparam int AW = 8;
`ifdef DATA_MEMORY_WRITE_THROUGH_EN
  localparam bit WRITE_FIRST = 1'b1;
`else
  localparam bit WRITE_FIRST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mem_write = 1'b0;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] input_data = '0;
  logic [DW-1:0] output_data;

  int tests = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  logic [DW-1:0] model_mem [256];
  logic [DW-1:0] model_out;

  data_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk),
    .reset(reset),
    .mem_write(mem_write),
    .address(address),
    .input_data(input_data),
    .output_data(output_data)
  );

  always #5 clk = ~clk;

  // Reference: a plain array plus a one-word output holder.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      foreach (model_mem[i]) model_mem[i] = '0;
      model_out = '0;
    end else begin
      if (mem_write && WRITE_FIRST) model_out = input_data;
      else model_out = model_mem[address];
      if (mem_write) model_mem[address] = input_data;
    end
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) check("model", output_data, model_out);
  end

  task automatic do_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    mem_write  = we;
    address    = a;
    input_data = d;
    @(posedge clk);
    #1;
    $display("[TB] %s addr=0x%02h din=0x%02h -> dout=0x%02h", we ? "WR" : "RD", a, d, output_data);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string name);
    do_op(1'b0, a, 8'h00);
    check(name, output_data, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("reset_hold", output_data, 8'h00);
    cmp_en = 1'b1;
    reset  = 1'b0;

    // Make the output nonzero, then clear it asynchronously between edges.
    do_op(1'b1, 8'h05, 8'h77);
    rd(8'h05, 8'h77, "pre_rst_rd");
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check("async_rst", output_data, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    rd(8'h00, 8'h00, "rst_rd_00");
    rd(8'h0A, 8'h00, "rst_rd_0a");
    rd(8'hFF, 8'h00, "rst_rd_ff");
    rd(8'h05, 8'h00, "rst_rd_05");

    // Writes held two cycles each.
    repeat (2) do_op(1'b1, 8'h00, 8'hAA);
    check("wr_hold_00", output_data, 8'hAA);
    repeat (2) do_op(1'b1, 8'hFF, 8'h55);
    repeat (2) do_op(1'b1, 8'h0A, 8'hF0);
    rd(8'h00, 8'hAA, "rd_00");
    rd(8'hFF, 8'h55, "rd_ff");
    rd(8'h0A, 8'hF0, "rd_0a");

    // Write disabled: data on the bus must not land.
    repeat (3) do_op(1'b0, 8'h0A, 8'h12);
    rd(8'h0A, 8'hF0, "wr_dis_0a");

    // Read-during-write on the same address.
    do_op(1'b1, 8'h0A, 8'h3C);
    check("rdw_edge", output_data, WRITE_FIRST ? 8'h3C : 8'hF0);
    rd(8'h0A, 8'h3C, "rdw_after");

    // Reset pulse during a write cycle: the write must be lost.
    @(negedge clk);
    mem_write  = 1'b1;
    address    = 8'h00;
    input_data = 8'h99;
    #2 reset = 1'b1;
    #1 check("mid_rst", output_data, 8'h00);
    @(posedge clk);
    #1 check("mid_rst_edge", output_data, 8'h00);
    @(negedge clk);
    reset     = 1'b0;
    mem_write = 1'b0;
    rd(8'h00, 8'h00, "mid_rd_00");
    rd(8'hFF, 8'h00, "mid_rd_ff");
    rd(8'h0A, 8'h00, "mid_rd_0a");

    // Back-to-back writes then reads.
    for (int i = 0; i < 4; i++) do_op(1'b1, 8'h10 + 8'(i), 8'h01 + 8'(i));
    rd(8'h10, 8'h01, "b2b_10");
    rd(8'h11, 8'h02, "b2b_11");
    rd(8'h12, 8'h03, "b2b_12");
    rd(8'h13, 8'h04, "b2b_13");

    @(negedge clk);
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
